// File: rtl/awgn_pkg.sv
// -----------------------------------------------------------------------------
// awgn_pkg
// Shared definitions for the AWGN datapath blocks.
//   EXP_W        : width of the shift exponent.
//   K_S1/S2/S3   : shift unit of each denormalizer stage (16, 4, 1).
//   stage_ctl_t  : per-stage record {valid, g, s, exp_rem}. The data word
//                  travels beside it because its width is a module parameter.
// -----------------------------------------------------------------------------
package awgn_pkg;

  localparam int EXP_W = 6;

  localparam int K_S1 = 16;
  localparam int K_S2 = 4;
  localparam int K_S3 = 1;

  // exp_rem is consumed two bits at a time from the top: every stage takes its
  // shift select from exp_rem[5:4] and hands the rest on shifted left by two.
  typedef struct packed {
    logic             valid;
    logic             g;
    logic             s;
    logic [EXP_W-1:0] exp_rem;
  } stage_ctl_t;

endpackage

// File: rtl/denorm_shifter_if.sv
// -----------------------------------------------------------------------------
// denorm_shifter_if
// Handshake bundle of the denormalizing shifter.
//   in_valid/in_ready   : input handshake for din/exp_e.
//   din, exp_e          : normalized operand and right-shift amount.
//   out_valid/out_ready : output handshake for dout/inexact/zero.
//   dout, inexact, zero : shifted (rounded) result and its flags.
// Modports: master = producer/consumer around the block, slave = the block.
// -----------------------------------------------------------------------------
interface denorm_shifter_if #(
  parameter int W = 48
);

  logic                       in_valid;
  logic                       in_ready;
  logic [W-1:0]               din;
  logic [awgn_pkg::EXP_W-1:0] exp_e;
  logic                       out_valid;
  logic                       out_ready;
  logic [W-1:0]               dout;
  logic                       inexact;
  logic                       zero;

  modport master (
    output in_valid, din, exp_e, out_ready,
    input  in_ready, out_valid, dout, inexact, zero
  );

  modport slave (
    input  in_valid, din, exp_e, out_ready,
    output in_ready, out_valid, dout, inexact, zero
  );

endinterface

// File: rtl/denorm_shifter_rshift_stage.sv
// -----------------------------------------------------------------------------
// rshift_stage
// One registered pipeline stage of the denormalizer. Shifts the data word right
// by K_UNIT * exp_rem[5:4], folding the bits shifted out into the guard (g) and
// sticky (s) bits. With SAT=1 the stage also handles exp >= W, where the whole
// word leaves the datapath.
//   clk, rst_n           : clock, synchronous active-low reset.
//   in_data, in_ctl      : upstream record (in_ctl.valid is the upstream valid).
//   up_ready             : this stage can take a record this cycle.
//   down_ready           : downstream stage (or consumer) can take our record.
//   out_data, out_ctl    : registered record.
// -----------------------------------------------------------------------------
module rshift_stage
  import awgn_pkg::*;
#(
  parameter int W      = 48,
  parameter int K_UNIT = 1,
  parameter bit SAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     in_data,
  input  stage_ctl_t       in_ctl,
  output logic             up_ready,
  input  logic             down_ready,
  output logic [W-1:0]     out_data,
  output stage_ctl_t       out_ctl
);

  logic [1:0]     sel;
  logic [2*W-1:0] wide;
  logic [W-1:0]   nxt_data;
  logic           nxt_g;
  logic           nxt_s;
  int             k;

  assign sel = in_ctl.exp_rem[EXP_W-1 -: 2];

  // The stage moves whenever its register is empty or is being emptied.
  assign up_ready = ~out_ctl.valid | down_ready;

  // NOTE: every output of this block gets a value before any branch, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    k        = K_UNIT * int'(sel);
    // Upper half is the shifted word, lower half holds what fell off the end.
    wide     = {in_data, {W{1'b0}}} >> k;
    nxt_data = wide[2*W-1:W];
    nxt_g    = in_ctl.g;
    nxt_s    = in_ctl.s;
    if (k != 0) begin
      nxt_g = wide[W-1];
      nxt_s = in_ctl.s | in_ctl.g | (|wide[W-2:0]);
    end
    // Shift of W or more: nothing is left in the word. Only a shift of
    // exactly W keeps the MSB as guard; everything else is sticky.
    if (SAT && (int'(in_ctl.exp_rem) >= W)) begin
      nxt_data = '0;
      if (int'(in_ctl.exp_rem) == W) begin
        nxt_g = in_data[W-1];
        nxt_s = in_ctl.s | in_ctl.g | (|in_data[W-2:0]);
      end else begin
        nxt_g = 1'b0;
        nxt_s = in_ctl.s | in_ctl.g | (|in_data);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every stage samples
  // its neighbour's pre-edge value and the pipeline shifts as a whole.
  // NOTE: the data word is reset along with the valid bit because the block's
  // dout must read 0 straight after reset, not stale or unknown contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_ctl  <= '0;
      out_data <= '0;
    end else if (up_ready) begin
      out_ctl.valid <= in_ctl.valid;
      // Bubbles only clear valid; the held record is left untouched.
      if (in_ctl.valid) begin
        out_data        <= nxt_data;
        out_ctl.g       <= nxt_g;
        out_ctl.s       <= nxt_s;
        out_ctl.exp_rem <= {in_ctl.exp_rem[EXP_W-3:0], 2'b00};
      end
    end
  end

endmodule

// File: rtl/denorm_shifter.sv
// -----------------------------------------------------------------------------
// denorm_shifter
// Three-stage pipelined right-shift denormalizer: dout = din >> exp_e, rounded
// half-up on the guard bit when ROUND=1, truncated when ROUND=0. Full
// valid/ready backpressure, 3-cycle latency, one result per cycle.
//   clk   : clock (rising edge).
//   rst_n : synchronous active-low reset; drops all in-flight data.
//   bus   : denorm_shifter_if slave (in_valid/in_ready/din/exp_e,
//           out_valid/out_ready/dout/inexact/zero).
// Parameters: W data width (<= 63), ROUND rounding enable.
// -----------------------------------------------------------------------------
module denorm_shifter
  import awgn_pkg::*;
#(
  parameter int W     = 48,
  parameter bit ROUND = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  denorm_shifter_if.slave bus
);

  stage_ctl_t   c0, c1, c2, c3;
  logic [W-1:0] d1, d2, d3;
  logic         rdy1, rdy2, rdy3;
  logic [W-1:0] result;
  logic         unused_exp_rem;

  assign c0 = '{valid: bus.in_valid, g: 1'b0, s: 1'b0, exp_rem: bus.exp_e};

  rshift_stage #(.W(W), .K_UNIT(K_S1), .SAT(1'b1)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (bus.din),
    .in_ctl    (c0),
    .up_ready  (rdy1),
    .down_ready(rdy2),
    .out_data  (d1),
    .out_ctl   (c1)
  );

  rshift_stage #(.W(W), .K_UNIT(K_S2), .SAT(1'b0)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (d1),
    .in_ctl    (c1),
    .up_ready  (rdy2),
    .down_ready(rdy3),
    .out_data  (d2),
    .out_ctl   (c2)
  );

  rshift_stage #(.W(W), .K_UNIT(K_S3), .SAT(1'b0)) u_s3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (d2),
    .in_ctl    (c2),
    .up_ready  (rdy3),
    .down_ready(bus.out_ready),
    .out_data  (d3),
    .out_ctl   (c3)
  );

  // Rounding cannot overflow: any nonzero shift leaves the word below
  // 2^(W-1), and a zero shift leaves g clear.
  assign result = ROUND ? d3 + {{(W-1){1'b0}}, c3.g} : d3;

  assign bus.in_ready  = rdy1;
  assign bus.out_valid = c3.valid;
  assign bus.dout      = result;
  assign bus.inexact   = c3.g | c3.s;
  // Qualified by valid so the flag reads 0 out of reset rather than
  // reporting the cleared data word as a zero result.
  assign bus.zero      = c3.valid & (result == '0);

  // All exponent bits are consumed by the last stage.
  assign unused_exp_rem = ^c3.exp_rem;

endmodule

// File: tb/tb_denorm_shifter.sv
module tb_denorm_shifter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  denorm_shifter_if #(.W(48)) bus ();
  denorm_shifter_if #(.W(48)) bus_t ();

  // Truncating instance sees exactly the same stimulus.
  assign bus_t.in_valid  = bus.in_valid;
  assign bus_t.din       = bus.din;
  assign bus_t.exp_e     = bus.exp_e;
  assign bus_t.out_ready = bus.out_ready;

  denorm_shifter #(.W(48), .ROUND(1'b1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  denorm_shifter #(.W(48), .ROUND(1'b0)) dut_t (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_t)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Reference: integer division by 2^e, round half up on the remainder.
  function automatic void ref_model(input logic [47:0] d, input logic [5:0] e,
                                    output logic [47:0] q_rnd, output logic [47:0] q_trn,
                                    output logic inx);
    longint unsigned pow, q, r;
    pow   = 64'd1 << e;
    q     = 64'(d) / pow;
    r     = 64'(d) % pow;
    q_trn = q[47:0];
    inx   = (r != 0);
    q_rnd = q[47:0] + (((r != 0) && (2 * r >= pow)) ? 48'd1 : 48'd0);
  endfunction

  typedef struct {
    logic [47:0] din;
    logic [5:0]  e;
    logic [47:0] q_rnd;
    logic [47:0] q_trn;
    logic        inexact;
  } vec_t;

  typedef struct {
    logic [47:0] q_rnd;
    logic [47:0] q_trn;
    logic        inexact;
  } exp_t;

  vec_t vecs[12];

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_dout"}, 64'(bus.dout), 64'd0);
    check({tag, "_inexact"}, 64'(bus.inexact), 64'd0);
    check({tag, "_zero"}, 64'(bus.zero), 64'd0);
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  // Single isolated transfer with exact latency check.
  task automatic send_one(input int idx);
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.din       = v.din;
    bus.exp_e     = v.e;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check($sformatf("vec%0d_early_valid", idx), 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check($sformatf("vec%0d_out_valid", idx), 64'(bus.out_valid), 64'd1);
    check($sformatf("vec%0d_dout", idx), 64'(bus.dout), 64'(v.q_rnd));
    check($sformatf("vec%0d_inexact", idx), 64'(bus.inexact), 64'(v.inexact));
    check($sformatf("vec%0d_zero", idx), 64'(bus.zero), 64'(v.q_rnd == 48'd0));
    check($sformatf("vec%0d_trunc_dout", idx), 64'(bus_t.dout), 64'(v.q_trn));
    check($sformatf("vec%0d_trunc_zero", idx), 64'(bus_t.zero), 64'(v.q_trn == 48'd0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.din       = '0;
    bus.exp_e     = '0;

    //         din                 e    rounded             truncated          inexact
    vecs[0]  = '{48'h8000_0000_0000, 6'd1,  48'h4000_0000_0000, 48'h4000_0000_0000, 1'b0};
    vecs[1]  = '{48'h0000_0000_0003, 6'd1,  48'd2,              48'd1,              1'b1};
    vecs[2]  = '{48'hFFFF_FFFF_FFFF, 6'd48, 48'd1,              48'd0,              1'b1};
    vecs[3]  = '{48'hFFFF_FFFF_FFFF, 6'd63, 48'd0,              48'd0,              1'b1};
    vecs[4]  = '{48'hABCD_EF01_2345, 6'd0,  48'hABCD_EF01_2345, 48'hABCD_EF01_2345, 1'b0};
    vecs[5]  = '{48'h0000_0000_0000, 6'd5,  48'd0,              48'd0,              1'b0};
    vecs[6]  = '{48'h0000_0000_0001, 6'd1,  48'd1,              48'd0,              1'b1};
    vecs[7]  = '{48'hFFFF_FFFF_FFFF, 6'd47, 48'd2,              48'd1,              1'b1};
    vecs[8]  = '{48'h8000_0000_0000, 6'd47, 48'd1,              48'd1,              1'b0};
    vecs[9]  = '{48'h0000_0000_0018, 6'd4,  48'd2,              48'd1,              1'b1};
    vecs[10] = '{48'h8000_0000_0000, 6'd49, 48'd0,              48'd0,              1'b1};
    vecs[11] = '{48'h1234_5678_9ABC, 6'd20, 48'h123_4568,       48'h123_4567,       1'b1};

    // Power-on reset.
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset");

    for (int i = 0; i < 12; i++) send_one(i);
    @(negedge clk);

    // Stream of 10 with out_ready low in cycles 4..8.
    begin
      int acc = 0, got = 0, extra = 0;
      bit saw_low = 1'b0, held_v = 1'b0;
      logic [47:0] held = '0;
      logic [47:0] qr, qt;
      logic ix;
      for (int c = 1; c <= 60 && got < 10; c++) begin
        @(negedge clk);
        bus.out_ready = !(c >= 4 && c <= 8);
        bus.in_valid  = (acc < 10);
        bus.din       = 48'hABCD_EF01_2345;
        bus.exp_e     = 6'(acc);
        #1;
        if (bus.in_valid && !bus.in_ready && !saw_low) begin
          saw_low = 1'b1;
          check("stream_in_ready_fall", 64'(acc), 64'd3);
        end
        if (held_v && bus.out_valid) check("stream_hold_dout", 64'(bus.dout), 64'(held));
        held_v = bus.out_valid && !bus.out_ready;
        held   = bus.dout;
        if (bus.out_valid && bus.out_ready) begin
          ref_model(48'hABCD_EF01_2345, 6'(got), qr, qt, ix);
          check($sformatf("stream_dout%0d", got), 64'(bus.dout), 64'(qr));
          check($sformatf("stream_inexact%0d", got), 64'(bus.inexact), 64'(ix));
          got++;
        end
        if (bus.in_valid && bus.in_ready) acc++;
      end
      bus.in_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (bus.out_valid) extra++;
      end
      check("stream_saw_in_ready_low", 64'(saw_low), 64'd1);
      check("stream_accepted", 64'(acc), 64'd10);
      check("stream_received", 64'(got), 64'd10);
      check("stream_no_extra", 64'(extra), 64'd0);
    end

    // Reset mid-flight.
    begin
      int seen = 0, first_k = -1;
      logic [47:0] first_dout = '0;
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.din       = 48'd7;
      bus.exp_e     = 6'd0;
      @(negedge clk);
      if (bus.out_valid) seen++;
      bus.din   = 48'd9;
      bus.exp_e = 6'd1;
      @(negedge clk);
      if (bus.out_valid) seen++;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (bus.out_valid) seen++;
        @(negedge clk);
      end
      check("midrst_no_output", 64'(seen), 64'd0);
      bus.in_valid = 1'b1;
      bus.din      = 48'd5;
      bus.exp_e    = 6'd0;
      seen = 0;
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (bus.out_valid) begin
          if (first_k < 0) begin
            first_k    = k;
            first_dout = bus.dout;
          end
          seen++;
        end
      end
      check("midrst_latency", 64'(first_k), 64'd3);
      check("midrst_count", 64'(seen), 64'd1);
      check("midrst_dout", 64'(first_dout), 64'd5);
    end

    // Random regression with random backpressure.
    begin
      localparam int N = 10000;
      exp_t sb[$];
      exp_t x;
      int sent = 0, rcvd = 0;
      bit pending = 1'b0;
      logic [63:0] rnd;
      for (int cyc = 0; cyc < 80000 && rcvd < N; cyc++) begin
        @(negedge clk);
        if (!pending && sent < N && $urandom_range(3) != 0) begin
          rnd       = {$urandom(), $urandom()};
          bus.din   = rnd[47:0];
          bus.exp_e = 6'($urandom_range(63));
          pending   = 1'b1;
        end
        bus.in_valid  = pending;
        bus.out_ready = ($urandom_range(3) != 0);
        #1;
        if (bus.in_valid && bus.in_ready) begin
          ref_model(bus.din, bus.exp_e, x.q_rnd, x.q_trn, x.inexact);
          sb.push_back(x);
          sent++;
          pending = 1'b0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            check("reg_unexpected_output", 64'd1, 64'd0);
          end else begin
            x = sb.pop_front();
            check("reg_dout", 64'(bus.dout), 64'(x.q_rnd));
            check("reg_inexact", 64'(bus.inexact), 64'(x.inexact));
            check("reg_zero", 64'(bus.zero), 64'(x.q_rnd == 48'd0));
            check("reg_trunc_dout", 64'(bus_t.dout), 64'(x.q_trn));
            check("reg_trunc_zero", 64'(bus_t.zero), 64'(x.q_trn == 48'd0));
          end
          rcvd++;
        end
      end
      bus.in_valid = 1'b0;
      check("reg_received", 64'(rcvd), 64'(N));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
